// File: rtl/apb_req_arbiter.sv
// Round-robin APB master that serialises single read/write commands from NUM_REQ requesters.
// Optional ACCESS timeout is compiled in with `define APB_TIMEOUT_EN.
module apb_req_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int addr_width     = 32,
    parameter int data_width     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                             pclk,
    input  logic                             presetn,
    input  logic [NUM_REQ-1:0]               req,
    input  logic [NUM_REQ-1:0]               req_write,
    input  logic [NUM_REQ*addr_width-1:0]    req_addr,
    input  logic [NUM_REQ*data_width-1:0]    req_wdata,
    output logic [NUM_REQ-1:0]               ack,
    output logic [data_width-1:0]            rsp_rdata,
    output logic                             rsp_err,
    output logic                             psel,
    output logic                             penable,
    output logic                             pwrite,
    output logic [addr_width-1:0]            paddr,
    output logic [data_width-1:0]            pwdata,
    output logic                             ptransfer,
    input  logic [data_width-1:0]            prdata,
    input  logic                             pready,
    input  logic                             pslverr
);

    localparam int IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_next_state;
    logic [IDXW-1:0]         r_ptr;
    logic [IDXW-1:0]         r_winner;
    logic [IDXW-1:0]         w_pick_idx;
    logic                    w_pick_found;
    logic                    w_grant;
    logic                    w_done;
    logic                    w_tmo;
    logic [NUM_REQ-1:0]      w_elig;
    logic [NUM_REQ-1:0]      w_cand;
    logic [NUM_REQ-1:0]      w_winner_oh;
    logic [NUM_REQ-1:0]      r_ack;
    logic [data_width-1:0]   r_rsp_rdata;
    logic                    r_rsp_err;
    logic                    r_psel;
    logic                    r_penable;
    logic                    r_pwrite;
    logic [addr_width-1:0]   r_paddr;
    logic [data_width-1:0]   r_pwdata;
    logic                    r_ptransfer;

    // A requester is masked during its own ack cycle so a late req drop cannot re-win.
    assign w_elig = req & ~r_ack;

    // One-hot form of the requester currently owning the bus.
    always_comb begin
        w_winner_oh           = '0;
        w_winner_oh[r_winner] = 1'b1;
    end

    assign w_cand = (r_state == ST_ACCESS) ? (w_elig & ~w_winner_oh) : w_elig;

    // Round-robin pick: first candidate at or after the pointer, wrapping.
    always_comb begin
        int              v_idx;
        logic [IDXW-1:0] v_sel;
        v_idx        = 0;
        v_sel        = '0;
        w_pick_found = 1'b0;
        w_pick_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            v_idx = int'(r_ptr) + k;
            if (v_idx >= NUM_REQ) begin
                v_idx = v_idx - NUM_REQ;
            end else begin
                v_idx = v_idx;
            end
            v_sel = IDXW'(v_idx);
            if (!w_pick_found && w_cand[v_sel]) begin
                w_pick_idx   = v_sel;
                w_pick_found = 1'b1;
            end else begin
                w_pick_idx   = w_pick_idx;
            end
        end
    end

`ifdef APB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] r_tmo_cnt;

    // Counts stalled ACCESS cycles; cleared at each SETUP.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_tmo_cnt <= '0;
        end else if (r_state == ST_SETUP) begin
            r_tmo_cnt <= '0;
        end else if ((r_state == ST_ACCESS) && !pready &&
                     (r_tmo_cnt != TMO_W'(TIMEOUT_CYCLES - 1))) begin
            r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
        end else begin
            r_tmo_cnt <= r_tmo_cnt;
        end
    end

    assign w_tmo = (r_state == ST_ACCESS) && !pready &&
                   (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`else
    logic w_unused_tmo_cfg;
    assign w_unused_tmo_cfg = (TIMEOUT_CYCLES > 0);
    assign w_tmo            = 1'b0;
`endif

    assign w_done = (r_state == ST_ACCESS) && (pready || w_tmo);

    // Next-state logic; a completing ACCESS may grant straight into SETUP.
    always_comb begin
        w_next_state = r_state;
        w_grant      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_found) begin
                    w_next_state = ST_SETUP;
                    w_grant      = 1'b1;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_SETUP: begin
                w_next_state = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (w_done && w_pick_found) begin
                    w_next_state = ST_SETUP;
                    w_grant      = 1'b1;
                end else if (w_done) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state = ST_ACCESS;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Registered APB bus, grant bookkeeping and response outputs.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_ptr       <= '0;
            r_winner    <= '0;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_pwrite    <= 1'b0;
            r_paddr     <= '0;
            r_pwdata    <= '0;
            r_ptransfer <= 1'b0;
            r_ack       <= '0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_psel      <= (w_next_state != ST_IDLE);
            r_penable   <= (w_next_state == ST_ACCESS);
            // The winner never changes while staying in or entering ACCESS.
            r_ptransfer <= (w_next_state == ST_ACCESS) && (|(w_elig & ~w_winner_oh));
            r_ack       <= w_done ? w_winner_oh : '0;
            if (w_grant) begin
                r_winner <= w_pick_idx;
                r_ptr    <= (w_pick_idx == IDXW'(NUM_REQ - 1)) ? '0 : (w_pick_idx + IDXW'(1));
                r_pwrite <= req_write[w_pick_idx];
                r_paddr  <= req_addr[int'(w_pick_idx)*addr_width +: addr_width];
                r_pwdata <= req_wdata[int'(w_pick_idx)*data_width +: data_width];
            end else begin
                r_winner <= r_winner;
                r_ptr    <= r_ptr;
                r_pwrite <= r_pwrite;
                r_paddr  <= r_paddr;
                r_pwdata <= r_pwdata;
            end
            if (w_done) begin
                r_rsp_rdata <= (w_tmo || r_pwrite) ? '0 : prdata;
                r_rsp_err   <= w_tmo ? 1'b1 : pslverr;
            end else begin
                r_rsp_rdata <= r_rsp_rdata;
                r_rsp_err   <= r_rsp_err;
            end
        end
    end

    assign ack       = r_ack;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;
    assign psel      = r_psel;
    assign penable   = r_penable;
    assign pwrite    = r_pwrite;
    assign paddr     = r_paddr;
    assign pwdata    = r_pwdata;
    assign ptransfer = r_ptransfer;

endmodule
